// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: word width, the NOP
// bubble encoding and the request state encoding.
package fetch_unit_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  // Bubble driven toward IF/ID whenever no real instruction is held.
  localparam word_t NOP_INSTR = 16'h0800;

  // IDLE: nothing outstanding.
  // WAIT: request outstanding, returned data will be kept.
  // DROP: request outstanding, returned data will be thrown away
  //       (a redirect arrived while it was in flight).
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction SRAM port shared between the fetch stage (master) and the
// SRAM controller (slave).
//
// Handshake: imemReq is a request that, once raised, stays high with
// imemAddr unchanged until the cycle imemReady is seen; that cycle is the
// transfer and imemData is valid in it. imemReady may come in the same
// cycle imemReq rises. imemReady while imemReq is low carries no meaning.
interface fetch_unit_if;

  logic                  imemReq;
  fetch_unit_pkg::word_t imemAddr;
  logic                  imemReady;
  fetch_unit_pkg::word_t imemData;

  modport master (
    output imemReq,
    output imemAddr,
    input  imemReady,
    input  imemData
  );

  modport slave (
    input  imemReq,
    input  imemAddr,
    output imemReady,
    output imemData
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over the shared SRAM port
// and holds one instruction for the IF/ID register. Redirects from branch
// resolution take priority over everything and discard in-flight fetches.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter word_t RESET_PC = 16'h0000
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                freeze,
  input  logic                branchTaken,
  input  word_t               branchTarget,
  input  logic                memBusy,
  fetch_unit_if.master        imem,
  output word_t               instructionOut,
  output word_t               PCOut,
  output logic                validOut,
  output state_t              fsm_state
);

  state_t state;
  state_t state_next;
  word_t  pc;
  word_t  req_addr;
  logic   issue;
  logic   accept;

  assign fsm_state = state;

  // Next-state, request drive and accept decision.
  // A new request only starts from IDLE when the SRAM is free, no redirect
  // is arriving and the output slot is empty or being consumed this cycle.
  // Once outstanding, the request is held on req_addr until ready.
  always_comb begin
    state_next    = state;
    issue         = 1'b0;
    accept        = 1'b0;
    imem.imemReq  = 1'b0;
    imem.imemAddr = pc;
    case (state)
      IDLE: begin
        issue        = !memBusy && !branchTaken && (!validOut || !freeze);
        imem.imemReq = issue;
        if (issue) begin
          if (imem.imemReady) begin
            accept = 1'b1;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        imem.imemReq  = 1'b1;
        imem.imemAddr = req_addr;
        if (imem.imemReady) begin
          // A redirect in the same cycle wins; the data is dropped.
          accept     = !branchTaken;
          state_next = IDLE;
        end else if (branchTaken) begin
          state_next = DROP;
        end
      end
      DROP: begin
        imem.imemReq  = 1'b1;
        imem.imemAddr = req_addr;
        if (imem.imemReady) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Program counter and captured request address.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      if (branchTaken) begin
        pc <= branchTarget;
      end else if (accept) begin
        pc <= pc + 16'd1;
      end
      if (issue) begin
        req_addr <= pc;
      end
    end
  end

  // IF/ID-facing output registers: redirect flushes, accept loads,
  // consumption without a replacement inserts a bubble, freeze holds.
  always_ff @(posedge CLK) begin
    if (RST) begin
      instructionOut <= NOP_INSTR;
      PCOut          <= 16'h0000;
      validOut       <= 1'b0;
    end else if (branchTaken) begin
      instructionOut <= NOP_INSTR;
      validOut       <= 1'b0;
    end else if (accept) begin
      instructionOut <= imem.imemData;
      PCOut          <= imem.imemAddr + 16'd1;
      validOut       <= 1'b1;
    end else if (!freeze) begin
      instructionOut <= NOP_INSTR;
      validOut       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed vector table, hand sequences for
// mid-request reset and PC wrap, then randomized traffic against a
// transaction-level reference model.
`timescale 1ns/1ps
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic   rst;
  logic   freeze;
  logic   branch_taken;
  word_t  branch_target;
  logic   mem_busy;
  word_t  instr_out;
  word_t  pc_out;
  logic   valid_out;
  state_t fsm_state;

  logic   rst_b;
  logic   freeze_b;
  logic   branch_b;
  word_t  target_b;
  logic   busy_b;
  word_t  instr_b;
  word_t  pc_b;
  logic   valid_b;
  state_t fsm_b;

  fetch_unit_if imem_a ();
  fetch_unit_if imem_b ();

  fetch_unit dut (
    .CLK(clk), .RST(rst), .freeze(freeze), .branchTaken(branch_taken),
    .branchTarget(branch_target), .memBusy(mem_busy), .imem(imem_a),
    .instructionOut(instr_out), .PCOut(pc_out), .validOut(valid_out),
    .fsm_state(fsm_state)
  );

  fetch_unit #(.RESET_PC(16'hFFFF)) dut_wrap (
    .CLK(clk), .RST(rst_b), .freeze(freeze_b), .branchTaken(branch_b),
    .branchTarget(target_b), .memBusy(busy_b), .imem(imem_b),
    .instructionOut(instr_b), .PCOut(pc_b), .validOut(valid_b),
    .fsm_state(fsm_b)
  );

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [32:0] exp_q[$];   // {valid, instruction, PCOut} predicted per cycle

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic  f;
    logic  br;
    word_t tgt;
    logic  mb;
    logic  rdy;
    word_t data;
    logic  e_req;
    word_t e_addr;
    logic  e_valid;
    word_t e_instr;
    word_t e_pcout;
  } vec_t;

  function automatic vec_t mk(input logic f, input logic br, input word_t tgt,
                              input logic mb, input logic rdy, input word_t d,
                              input logic er, input word_t ea, input logic ev,
                              input word_t ei, input word_t ep);
    vec_t v;
    v.f = f; v.br = br; v.tgt = tgt; v.mb = mb; v.rdy = rdy; v.data = d;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_instr = ei; v.e_pcout = ep;
    return v;
  endfunction

  localparam int NVEC = 20;
  vec_t tbl[NVEC];

  // ---------------- driver tasks ----------------
  task automatic drive(input logic f, input logic br, input word_t tgt,
                       input logic mb, input logic rdy, input word_t d);
    freeze = f; branch_taken = br; branch_target = tgt; mem_busy = mb;
    imem_a.imemReady = rdy; imem_a.imemData = d;
  endtask

  task automatic check_outputs(input string tag, input logic ev, input word_t ei, input word_t ep);
    check({tag, "_valid"}, {15'b0, valid_out}, {15'b0, ev});
    check({tag, "_instr"}, instr_out, ei);
    check({tag, "_pcout"}, pc_out, ep);
  endtask

  // ---------------- reference model ----------------
  // Tracks the PC, whether a request is outstanding, whether its data is
  // still wanted, and the instruction slot seen by IF/ID.
  word_t m_pc, m_req_addr, m_instr, m_pcout;
  logic  m_pending, m_discard, m_valid;
  int    remaining;

  task automatic model_reset(input word_t rpc);
    m_pc = rpc; m_req_addr = rpc; m_pending = 1'b0; m_discard = 1'b0;
    m_valid = 1'b0; m_instr = NOP_INSTR; m_pcout = 16'h0000; remaining = 0;
  endtask

  task automatic random_cycle();
    logic  exp_req, ready, got, useful;
    word_t exp_addr, data;
    logic [32:0] e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rand_valid", {15'b0, valid_out}, {15'b0, e[32]});
      check("rand_instr", instr_out, e[31:16]);
      check("rand_pcout", pc_out, e[15:0]);
    end
    freeze        = ($urandom_range(0, 2) == 0);
    branch_taken  = ($urandom_range(0, 7) == 0);
    branch_target = word_t'($urandom);
    mem_busy      = ($urandom_range(0, 3) == 0);
    exp_req  = m_pending || (!mem_busy && !branch_taken && (!m_valid || !freeze));
    exp_addr = m_pending ? m_req_addr : m_pc;
    if (exp_req && !m_pending) remaining = $urandom_range(0, 2);
    else if (m_pending) remaining--;
    ready = exp_req ? (remaining == 0) : ($urandom_range(0, 7) == 0);
    data  = word_t'($urandom);
    imem_a.imemReady = ready;
    imem_a.imemData  = data;
    #1;
    check("rand_req", {15'b0, imem_a.imemReq}, {15'b0, exp_req});
    if (exp_req) check("rand_addr", imem_a.imemAddr, exp_addr);
    got    = exp_req && ready;
    useful = got && !m_discard && !branch_taken;
    if (branch_taken) begin
      m_valid = 1'b0; m_instr = NOP_INSTR;
    end else if (useful) begin
      m_valid = 1'b1; m_instr = data; m_pcout = exp_addr + 16'd1;
    end else if (!freeze) begin
      m_valid = 1'b0; m_instr = NOP_INSTR;
    end
    if (branch_taken) m_pc = branch_target;
    else if (useful) m_pc = m_pc + 16'd1;
    if (got) begin
      m_pending = 1'b0; m_discard = 1'b0;
    end else if (exp_req) begin
      m_discard  = (m_pending && m_discard) || branch_taken;
      m_pending  = 1'b1;
      m_req_addr = exp_addr;
    end
    exp_q.push_back({m_valid, m_instr, m_pcout});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; rst_b = 1'b1;
    freeze_b = 1'b0; branch_b = 1'b0; target_b = 16'h0000; busy_b = 1'b0;
    imem_b.imemReady = 1'b1; imem_b.imemData = 16'h0000;
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);

    //         f  br tgt       mb rdy data      req addr     v  instr     pcout
    tbl[0]  = mk(0, 0, 16'h0000, 0, 1, 16'hA000, 1, 16'h0000, 1, 16'hA000, 16'h0001);
    tbl[1]  = mk(0, 0, 16'h0000, 0, 1, 16'hA001, 1, 16'h0001, 1, 16'hA001, 16'h0002);
    tbl[2]  = mk(0, 0, 16'h0000, 0, 1, 16'hA002, 1, 16'h0002, 1, 16'hA002, 16'h0003);
    tbl[3]  = mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'hA002, 16'h0003);
    tbl[4]  = mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'hA002, 16'h0003);
    tbl[5]  = mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'hA002, 16'h0003);
    tbl[6]  = mk(0, 0, 16'h0000, 0, 1, 16'hA003, 1, 16'h0003, 1, 16'hA003, 16'h0004);
    tbl[7]  = mk(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 0, NOP_INSTR, 16'h0004);
    tbl[8]  = mk(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 0, NOP_INSTR, 16'h0004);
    tbl[9]  = mk(0, 0, 16'h0000, 0, 1, 16'hA004, 1, 16'h0004, 1, 16'hA004, 16'h0005);
    tbl[10] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0005, 0, NOP_INSTR, 16'h0005);
    tbl[11] = mk(0, 1, 16'h0040, 0, 0, 16'h0000, 1, 16'h0005, 0, NOP_INSTR, 16'h0005);
    tbl[12] = mk(0, 0, 16'h0000, 0, 1, 16'hBAD0, 1, 16'h0005, 0, NOP_INSTR, 16'h0005);
    tbl[13] = mk(0, 0, 16'h0000, 0, 1, 16'hA040, 1, 16'h0040, 1, 16'hA040, 16'h0041);
    tbl[14] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0041, 0, NOP_INSTR, 16'h0041);
    tbl[15] = mk(0, 1, 16'h0010, 0, 1, 16'hBAD1, 1, 16'h0041, 0, NOP_INSTR, 16'h0041);
    tbl[16] = mk(0, 0, 16'h0000, 0, 1, 16'hA010, 1, 16'h0010, 1, 16'hA010, 16'h0011);
    tbl[17] = mk(1, 1, 16'h0020, 0, 0, 16'h0000, 0, 16'h0000, 0, NOP_INSTR, 16'h0011);
    tbl[18] = mk(1, 0, 16'h0000, 0, 1, 16'hA020, 1, 16'h0020, 1, 16'hA020, 16'h0021);
    tbl[19] = mk(1, 0, 16'h0000, 0, 1, 16'hBAD2, 0, 16'h0000, 1, 16'hA020, 16'h0021);

    // Reset values (memBusy keeps the unit quiet for one extra cycle).
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_outputs("reset", 1'b0, NOP_INSTR, 16'h0000);
    check("reset_state", {14'b0, fsm_state}, {14'b0, IDLE});
    check("reset_req", {15'b0, imem_a.imemReq}, 16'h0000);

    // Directed table.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(tbl[i].f, tbl[i].br, tbl[i].tgt, tbl[i].mb, tbl[i].rdy, tbl[i].data);
      #1;
      check($sformatf("vec%0d_req", i), {15'b0, imem_a.imemReq}, {15'b0, tbl[i].e_req});
      if (tbl[i].e_req) check($sformatf("vec%0d_addr", i), imem_a.imemAddr, tbl[i].e_addr);
      @(posedge clk);
      #1;
      check_outputs($sformatf("vec%0d", i), tbl[i].e_valid, tbl[i].e_instr, tbl[i].e_pcout);
    end

    // Reset while a request is outstanding: later ready must be ignored.
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    #1;
    check("midrst_req", {15'b0, imem_a.imemReq}, 16'h0001);
    check("midrst_addr", imem_a.imemAddr, 16'h0021);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hBAD3);
    #1;
    check("midrst_idle_req", {15'b0, imem_a.imemReq}, 16'h0000);
    @(posedge clk);
    #1;
    check_outputs("midrst_ignored", 1'b0, NOP_INSTR, 16'h0000);
    check("midrst_state", {14'b0, fsm_state}, {14'b0, IDLE});
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hA000);
    #1;
    check("midrst_resume_addr", imem_a.imemAddr, 16'h0000);
    @(posedge clk);
    #1;
    check_outputs("midrst_resume", 1'b1, 16'hA000, 16'h0001);

    // PC wrap on the second instance (RESET_PC = FFFF).
    @(negedge clk);
    rst_b = 1'b0;
    imem_b.imemData = 16'hE0FF;
    #1;
    check("wrap_req0", {15'b0, imem_b.imemReq}, 16'h0001);
    check("wrap_addr0", imem_b.imemAddr, 16'hFFFF);
    @(posedge clk);
    #1;
    check("wrap_valid0", {15'b0, valid_b}, 16'h0001);
    check("wrap_instr0", instr_b, 16'hE0FF);
    check("wrap_pcout0", pc_b, 16'h0000);
    @(negedge clk);
    imem_b.imemData = 16'hE000;
    #1;
    check("wrap_addr1", imem_b.imemAddr, 16'h0000);
    @(posedge clk);
    #1;
    check("wrap_instr1", instr_b, 16'hE000);
    check("wrap_pcout1", pc_b, 16'h0001);
    @(negedge clk);
    rst_b = 1'b1;

    // Randomized traffic against the reference model.
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    model_reset(16'h0000);
    exp_q.delete();
    for (int n = 0; n < 3000; n++) begin
      random_cycle();
    end
    @(negedge clk);
    if (exp_q.size() > 0) begin
      logic [32:0] e;
      e = exp_q.pop_front();
      check("rand_last_valid", {15'b0, valid_out}, {15'b0, e[32]});
      check("rand_last_pcout", pc_out, e[15:0]);
    end

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
